alu_div_seq: RTL and testbench

ALU_DIV_SEQ -- requirements
Module: alu_div_seq

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_div_step.sv | 25 ++
 rtl/alu_div_seq.sv | 109 ++++++++++
 tb/tb_alu_div_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the sequential divider
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 32;

  // Divide-by-zero quotient is all-ones at any width: replicate this bit.
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/alu_div_step.sv
// rtl/alu_div_step.sv - one restoring shift-subtract step of the divider
module alu_div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor, so a borrow shows up exactly in the top bit of diff.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle signed/unsigned restoring divider
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dsr, rem, q_work;
  logic [WIDTH-1:0] rem_nxt, a_abs, b_abs;
  logic             q_bit, neg_q, neg_r, last_step;

  assign a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign last_step = (cnt == CW'(WIDTH - 1));

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .divisor (dsr),
    .dvd_bit (dvd[WIDTH-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (b == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last_step) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      q_work      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (b == '0) begin
              quotient    <= {WIDTH{DBZ_Q_FILL}};
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              dvd         <= a_abs;
              dsr         <= b_abs;
              rem         <= '0;
              q_work      <= '0;
              cnt         <= '0;
              neg_q       <= is_signed && (a[WIDTH-1] != b[WIDTH-1]);
              neg_r       <= is_signed && a[WIDTH-1];
              div_by_zero <= 1'b0;
            end
          end
        end
        S_RUN: begin
          rem    <= rem_nxt;
          q_work <= {q_work[WIDTH-2:0], q_bit};
          dvd    <= {dvd[WIDTH-2:0], 1'b0};
          cnt    <= cnt + CW'(1);
        end
        // Most-negative / -1 needs no special case: negating 2^(W-1) wraps to itself.
        S_FIX: begin
          quotient  <= neg_q ? -q_work : q_work;
          remainder <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - scoreboard bench for alu_div_seq
module tb_alu_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, is_signed;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  alu_div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient",    quotient,        e.q);
        chk("remainder",   remainder,       e.r);
        chk("div_by_zero", W'(div_by_zero), W'(e.dbz));
        chk("done_cycle",  W'(cyc),         W'(e.cyc));
      end
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                       input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; is_signed = s; a = aa; b = bb;
    e.q = eq; e.r = er; e.dbz = ed; e.cyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; is_signed = ~s; a = $urandom; b = $urandom;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d results outstanding", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ed, input int lat);
    issue(s, aa, bb, eq, er, ed, lat);
    wait_drain(name);
    repeat (2) @(negedge clk);
    chk({name, "_hold_q"}, quotient, eq);
    chk({name, "_hold_r"}, remainder, er);
    chk({name, "_idle"}, W'(busy), W'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_q",    quotient, '0);
    chk("rst_r",    remainder, '0);
    chk("rst_dbz",  W'(div_by_zero), W'(0));
    rst = 1'b0;

    run_op("udiv_100_7",   1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, 34);
    run_op("sdiv_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 1'b0, 34);
    run_op("udiv_5_0",     1'b0, 32'd5,          32'd0,        32'hFFFFFFFF,  32'd5,        1'b1, 1);
    run_op("sdiv_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        1'b0, 34);
    run_op("sdiv_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        1'b0, 34);
    run_op("sdiv_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,        32'hFFFFFFFE, 1'b0, 34);
    run_op("udiv_max_16",  1'b0, 32'hFFFFFFFF,   32'h10,       32'h0FFFFFFF,  32'hF,        1'b0, 34);
    run_op("sdiv_m5_0",    1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,  32'hFFFFFFFB, 1'b1, 1);

    // Starts in RUN cycles 3 and 20, then in the DONE cycle, must all be ignored.
    issue(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 34);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    start = 1'b1; a = 32'd9; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_in_run", W'(busy), W'(1));
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_done_seen", W'(done), W'(1));
    start = 1'b1; a = 32'd77; b = 32'd7; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", W'(busy), W'(0));
    chk("ignore_q_kept", quotient, 32'd30);
    wait_drain("ignore_drain");

    // Reset in RUN cycle 10 aborts the operation without a done pulse.
    issue(1'b0, 32'd12345, 32'd11, 32'd1122, 32'd3, 1'b0, 34);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    chk("midrst_q",    quotient, '0);
    chk("midrst_r",    remainder, '0);
    chk("midrst_dbz",  W'(div_by_zero), W'(0));
    repeat (40) @(negedge clk);

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start", W'(busy), W'(0));

    run_op("post_rst", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
